// File: rtl/signed_sat_accumulator.sv
// -----------------------------------------------------------------------------
// signed_sat_accumulator
//
// Streaming signed accumulator. Each group of BURST_LEN two's-complement
// samples is summed into one result. The result is held in a one-entry
// output register with a valid/ready handshake. out_sat is a sticky flag:
// it is set if any add inside the burst overflowed. SATURATE selects the
// overflow behaviour. With SATURATE=1 the sum clamps to the most positive
// or most negative value. With SATURATE=0 the sum wraps modulo 2^WIDTH.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   clear      synchronous discard of the partial burst (output untouched)
//   in_valid   in_data carries a sample
//   in_ready   block can take in_data this cycle (combinational)
//   in_data    signed sample, WIDTH bits
//   out_valid  out_data/out_sat hold a burst result
//   out_ready  consumer takes the result this cycle
//   out_data   signed burst sum, WIDTH bits
//   out_sat    at least one overflow occurred during the burst
//
// Handshake rules (both ports):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer holds valid and its data stable until that transfer happens.
//   in_ready depends combinationally on out_ready and clear. It does not
//   depend on in_valid. out_valid depends only on registered state.
// -----------------------------------------------------------------------------
module signed_sat_accumulator #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter bit SATURATE  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    // A 1-bit counter is kept even for BURST_LEN=1. In that case it never
    // leaves zero, so every sample closes its own burst.
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] VAL_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] VAL_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    // Accumulation state
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sticky;

    // Datapath
    logic             last;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [WIDTH-1:0] result;

    assign last  = (cnt == CNT_LAST);
    assign drain = out_valid && out_ready;

    // Only the burst-closing sample needs a free output slot. The slot is
    // free if it is empty or is being drained this same cycle. Samples in
    // the middle of a burst keep flowing while a result waits downstream.
    assign in_ready = !clear && !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // Signed overflow: the operands have the same sign, but the wrapped sum
    // has a different sign.
    assign sum = acc + in_data;
    assign ovf = (acc[WIDTH-1] == in_data[WIDTH-1]) &&
                 (sum[WIDTH-1] != acc[WIDTH-1]);

    // On overflow the clamp direction follows the sample's sign. The
    // clamped value becomes the new accumulator, so a later sample of the
    // opposite sign does not undo the clamp.
    always_comb begin
        result = sum;
        if (SATURATE && ovf) begin
            result = in_data[WIDTH-1] ? VAL_MIN : VAL_MAX;
        end
    end

    // Accumulator, beat counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (clear) begin
            acc    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (accept) begin
            if (last) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else begin
                acc    <= result;
                cnt    <= cnt + CNT_ONE;
                sticky <= sticky | ovf;
            end
        end
    end

    // Output register. A new load takes priority over a drain, so a load
    // and a drain in the same cycle leave out_valid high with the new data.
    // After a drain with no load, out_data/out_sat keep their last value.
    // clear does not touch this register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (accept && last) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_sat   <= sticky | ovf;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// -----------------------------------------------------------------------------
// tb_signed_sat_accumulator
//
// Three instances share one stimulus stream, all with WIDTH=4:
//   dut_sat   BURST_LEN=4, SATURATE=1
//   dut_wrap  BURST_LEN=4, SATURATE=0
//   dut_b1    BURST_LEN=1, SATURATE=1, out_ready tied high
// dut_b1 only sees a sample when dut_sat accepts that sample. Because of
// this, every instance consumes exactly the same sample sequence.
// -----------------------------------------------------------------------------
module tb_signed_sat_accumulator;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic         clear     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         out_ready = 1'b1;

    logic         s_in_ready, s_out_valid, s_out_sat;
    logic [W-1:0] s_out_data;
    logic         w_in_ready, w_out_valid, w_out_sat;
    logic [W-1:0] w_out_data;
    logic         b_in_ready, b_out_valid, b_out_sat;
    logic [W-1:0] b_out_data;
    logic         b_in_valid;

    assign b_in_valid = in_valid && s_in_ready;

    signed_sat_accumulator #(.WIDTH(W), .BURST_LEN(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_sat(s_out_sat)
    );

    signed_sat_accumulator #(.WIDTH(W), .BURST_LEN(4), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_sat(w_out_sat)
    );

    signed_sat_accumulator #(.WIDTH(W), .BURST_LEN(1), .SATURATE(1'b1)) dut_b1 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(1'b1),
        .out_data(b_out_data), .out_sat(b_out_sat)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    // Each queue entry is {sat, data}.
    logic [W:0] exp_sat_q[$];
    logic [W:0] exp_wrap_q[$];
    logic [W:0] exp_b1_q[$];

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [3:0][W-1:0] s;    // s[0] is the first sample of the burst
        logic [W-1:0]      sd;   // saturating result
        logic              ss;
        logic [W-1:0]      wd;   // wrapping result
        logic              ws;
    } vec_t;

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int sd, input int ss, input int wd, input int ws);
        vec_t v;
        v.s[0] = W'(a);
        v.s[1] = W'(b);
        v.s[2] = W'(c);
        v.s[3] = W'(d);
        v.sd   = W'(sd);
        v.ss   = ss[0];
        v.wd   = W'(wd);
        v.ws   = ws[0];
        return v;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (s_out_valid && out_ready) begin
                if (exp_sat_q.size() == 0) check("sat_unexpected", {s_out_sat, s_out_data}, 'x);
                else check("sat_result", {s_out_sat, s_out_data}, exp_sat_q.pop_front());
            end
            if (w_out_valid && out_ready) begin
                if (exp_wrap_q.size() == 0) check("wrap_unexpected", {w_out_sat, w_out_data}, 'x);
                else check("wrap_result", {w_out_sat, w_out_data}, exp_wrap_q.pop_front());
            end
            if (b_out_valid) begin
                if (exp_b1_q.size() == 0) check("b1_unexpected", {b_out_sat, b_out_data}, 'x);
                else check("b1_result", {b_out_sat, b_out_data}, exp_b1_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present one sample and hold it until dut_sat accepts it.
    task automatic send(input logic [W-1:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!s_in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!s_in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stuck low for sample %b", d);
        end else begin
            exp_b1_q.push_back({1'b0, d});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected results are queued before the samples are sent. After the
    // last sample, check that the result appears on the very next cycle.
    task automatic run_burst(input vec_t v);
        exp_sat_q.push_back({v.ss, v.sd});
        exp_wrap_q.push_back({v.ws, v.wd});
        for (int i = 0; i < 4; i++) send(v.s[i]);
        @(negedge clk);
        check("latency_valid", {{W{1'b0}}, s_out_valid}, {{W{1'b0}}, 1'b1});
        @(posedge clk);
        #1;
    endtask

    // ---------------- main test ----------------
    vec_t vecs[7];

    initial begin
        vecs[0] = mk( 1,  2,  3,  1,   7, 0,   7, 0);
        vecs[1] = mk( 5,  5, -3,  1,   5, 1,  -8, 1);
        vecs[2] = mk(-8, -1,  0,  0,  -8, 1,   7, 1);
        vecs[3] = mk( 0,  0,  0,  0,   0, 0,   0, 0);
        vecs[4] = mk(-3,  2, -4, -1,  -6, 0,  -6, 0);
        vecs[5] = mk( 7,  1, -1, -1,   5, 1,   6, 1);
        vecs[6] = mk( 4,  4, -8,  0,  -1, 1,   0, 1);

        // Reset state
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {s_out_sat, s_out_data}, '0);
        check("reset_valid", {{W{1'b0}}, s_out_valid}, '0);
        check("reset_in_ready", {{W{1'b0}}, s_in_ready}, {{W{1'b0}}, 1'b1});
        @(posedge clk);
        #1;

        // Table-driven bursts, with an idle gap of random length between them
        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i]);
            idle($urandom_range(0, 2));
        end
        idle(2);

        // Backpressure: burst A is held while burst B tries to close
        out_ready = 1'b0;
        exp_sat_q.push_back({1'b0, 4'd4});
        exp_wrap_q.push_back({1'b0, 4'd4});
        for (int i = 0; i < 4; i++) send(4'd1);
        exp_sat_q.push_back({1'b1, 4'd7});
        exp_wrap_q.push_back({1'b1, 4'h8});
        for (int i = 0; i < 3; i++) send(4'd2);
        fork
            send(4'd2);
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", {{W{1'b0}}, s_in_ready}, '0);
                check("bp_wrap_in_ready", {{W{1'b0}}, w_in_ready}, '0);
                check("bp_hold", {s_out_valid, s_out_data}, {1'b1, 4'd4});
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        // clear discards the partial burst and blocks the sample offered with it
        send(4'd3);
        send(4'd3);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd5;
        @(negedge clk);
        check("clear_in_ready", {{W{1'b0}}, s_in_ready}, '0);
        check("clear_wrap_in_ready", {{W{1'b0}}, w_in_ready}, '0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        run_burst(mk(1, 1, 1, 1, 4, 0, 4, 0));
        idle(2);

        // Reset in the middle of a burst
        send(4'd3);
        send(4'd3);
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_sat_out", {s_out_sat, s_out_data}, '0);
        check("midrst_sat_valid", {{W{1'b0}}, s_out_valid}, '0);
        check("midrst_wrap_out", {w_out_valid, w_out_data}, '0);
        @(posedge clk);
        #1;
        run_burst(mk(1, 1, 1, 1, 4, 0, 4, 0));
        idle(4);

        check("sat_q_empty", W'(exp_sat_q.size()), '0);
        check("wrap_q_empty", W'(exp_wrap_q.size()), '0);
        check("b1_q_empty", W'(exp_b1_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
